// File: rtl/rs232_tx_reply.sv
// 8N1 UART transmitter fed by a small byte FIFO; drives USB_RXD toward the host PC.
// Frames are sent LSB first at CLK_DIV clocks per bit, with no gap between queued bytes.
module rs232_tx_reply #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 3
) (
    input  logic       iCLK,
    input  logic       iNRST,
    input  logic       iWR,
    input  logic [7:0] iDATA,
    output logic       oFULL,
    output logic       oEMPTY,
    output logic       oBUSY,
    output logic       oOVERFLOW,
    output logic       oTXD
);

    localparam int          DEPTH    = 1 << FIFO_AW;
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wrPtr_q, rdPtr_q;
    logic [FIFO_AW:0] wrPtr_d, rdPtr_d;
    logic             overflow_q;
    state_t           state_q;
    logic [15:0]      baudCnt_q;
    logic [2:0]       bitIdx_q;
    logic [7:0]       shift_q;
    logic             txd_q;

    logic       push;
    logic       pop;
    logic       bitTick;
    logic [7:0] headData;

    assign oEMPTY   = (wrPtr_q == rdPtr_q);
    assign oFULL    = (wrPtr_q[FIFO_AW] != rdPtr_q[FIFO_AW]) &&
                      (wrPtr_q[FIFO_AW-1:0] == rdPtr_q[FIFO_AW-1:0]);
    assign bitTick  = (baudCnt_q == DIV_LAST);
    assign push     = iWR && !oFULL;
    // The FSM pops from IDLE, or at the end of a stop bit to chain frames without a gap.
    assign pop      = !oEMPTY && ((state_q == IDLE) || (state_q == STOP && bitTick));
    assign headData = mem_q[rdPtr_q[FIFO_AW-1:0]];
    assign wrPtr_d  = wrPtr_q + {{FIFO_AW{1'b0}}, push};
    assign rdPtr_d  = rdPtr_q + {{FIFO_AW{1'b0}}, pop};

    assign oBUSY     = (state_q != IDLE) || !oEMPTY;
    assign oOVERFLOW = overflow_q;
    assign oTXD      = txd_q;

    always_ff @(posedge iCLK) begin
        if (push) begin
            mem_q[wrPtr_q[FIFO_AW-1:0]] <= iDATA;
        end
    end

    always_ff @(posedge iCLK or negedge iNRST) begin
        if (!iNRST) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            if (iWR && oFULL) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iNRST) begin
        if (!iNRST) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q     <= 1'b1;
                    baudCnt_q <= '0;
                    if (pop) begin
                        shift_q  <= headData;
                        bitIdx_q <= '0;
                        txd_q    <= 1'b0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (bitTick) begin
                        baudCnt_q <= '0;
                        txd_q     <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bitIdx_q  <= '0;
                        state_q   <= DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bitTick) begin
                        baudCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            txd_q    <= shift_q[0];
                            shift_q  <= {1'b0, shift_q[7:1]};
                            bitIdx_q <= bitIdx_q + 3'd1;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (bitTick) begin
                        baudCnt_q <= '0;
                        if (pop) begin
                            shift_q  <= headData;
                            bitIdx_q <= '0;
                            txd_q    <= 1'b0;
                            state_q  <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + 16'd1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx_reply.sv
// Directed bench for rs232_tx_reply: a fast instance (CLK_DIV=4) for frame-level timing
// and a default-rate instance (CLK_DIV=434) for the 115200 baud frame.
module tb_rs232_tx_reply;

    localparam int DIV  = 4;
    localparam int SDIV = 434;

    logic       clock = 1'b0;
    logic       nrst  = 1'b0;
    logic       wrF = 1'b0, wrS = 1'b0;
    logic [7:0] dataF = 8'h00, dataS = 8'h00;
    logic       fullF, emptyF, busyF, ovfF, txdF;
    logic       fullS, emptyS, busyS, ovfS, txdS;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rs232_tx_reply #(.CLK_DIV(DIV), .FIFO_AW(3)) dut (
        .iCLK(clock), .iNRST(nrst), .iWR(wrF), .iDATA(dataF),
        .oFULL(fullF), .oEMPTY(emptyF), .oBUSY(busyF), .oOVERFLOW(ovfF), .oTXD(txdF)
    );

    rs232_tx_reply #(.CLK_DIV(SDIV), .FIFO_AW(3)) dutSlow (
        .iCLK(clock), .iNRST(nrst), .iWR(wrS), .iDATA(dataS),
        .oFULL(fullS), .oEMPTY(emptyS), .oBUSY(busyS), .oOVERFLOW(ovfS), .oTXD(txdS)
    );

    // Expected line level for bit slot idx of a frame: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic frameBit(input logic [7:0] value, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return value[idx-1];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wrF = 1'($urandom_range(0, 1)); dataF = 8'($urandom);
            wrS = 1'($urandom_range(0, 1)); dataS = 8'($urandom);
            step();
        end
        checks += 6;
        if (txdF !== 1'b1)   begin errors++; $display("[TB] FAIL reset txd got %b want 1", txdF); end
        if (emptyF !== 1'b1) begin errors++; $display("[TB] FAIL reset empty got %b want 1", emptyF); end
        if (fullF !== 1'b0)  begin errors++; $display("[TB] FAIL reset full got %b want 0", fullF); end
        if (busyF !== 1'b0)  begin errors++; $display("[TB] FAIL reset busy got %b want 0", busyF); end
        if (ovfF !== 1'b0)   begin errors++; $display("[TB] FAIL reset overflow got %b want 0", ovfF); end
        if (txdS !== 1'b1 || emptyS !== 1'b1 || busyS !== 1'b0 || ovfS !== 1'b0 || fullS !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset slow txd/empty/busy/ovf/full got %b%b%b%b%b want 11000",
                     txdS, emptyS, busyS, ovfS, fullS);
        end
        wrF = 1'b0; wrS = 1'b0;
        nrst = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        wrF = 1'b1; dataF = 8'h55;
        step();
        wrF = 1'b0;
        checks += 2;
        if (emptyF !== 1'b0) begin errors++; $display("[TB] FAIL single empty after write got %b want 0", emptyF); end
        if (txdF !== 1'b1)   begin errors++; $display("[TB] FAIL single txd before pop got %b want 1", txdF); end
        step();
        checks++;
        if (emptyF !== 1'b1) begin errors++; $display("[TB] FAIL single empty after pop got %b want 1", emptyF); end
        for (int j = 0; j < 10*DIV; j++) begin
            if (j != 0) step();
            checks += 2;
            if (txdF !== frameBit(8'h55, j/DIV)) begin
                errors++; $display("[TB] FAIL single txd cycle %0d got %b want %b", j, txdF, frameBit(8'h55, j/DIV));
            end
            if (busyF !== 1'b1) begin errors++; $display("[TB] FAIL single busy cycle %0d got %b want 1", j, busyF); end
        end
        step();
        checks += 2;
        if (busyF !== 1'b0) begin errors++; $display("[TB] FAIL single busy end got %b want 0", busyF); end
        if (txdF !== 1'b1)  begin errors++; $display("[TB] FAIL single txd end got %b want 1", txdF); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [7:0] got [3];
        bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hFF;
        for (int f = 0; f < 3; f++) got[f] = 8'h00;
        wrF = 1'b1; dataF = bytes[0];
        for (int n = 0; n <= 30*DIV + 1; n++) begin
            step();
            if (n < 2) dataF = bytes[n+1];
            else if (n == 2) wrF = 1'b0;
            if (n >= 1 && n <= 30*DIV) begin
                int j, f, b;
                j = n - 1; f = j / (10*DIV); b = (j % (10*DIV)) / DIV;
                checks++;
                if (txdF !== frameBit(bytes[f], b)) begin
                    errors++; $display("[TB] FAIL burst txd cycle %0d got %b want %b", j, txdF, frameBit(bytes[f], b));
                end
                if (b >= 1 && b <= 8 && (j % DIV) == DIV/2) got[f][b-1] = txdF;
            end
            if (n == 30*DIV + 1) begin
                checks += 2;
                if (busyF !== 1'b0) begin errors++; $display("[TB] FAIL burst busy end got %b want 0", busyF); end
                if (txdF !== 1'b1)  begin errors++; $display("[TB] FAIL burst txd end got %b want 1", txdF); end
            end
        end
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (got[f] !== bytes[f]) begin
                errors++; $display("[TB] FAIL burst decode frame %0d got %h want %h", f, got[f], bytes[f]);
            end
        end
    endtask

    task automatic test_stop_gap();
        wrF = 1'b1; dataF = 8'h3C;
        step();
        wrF = 1'b0;
        repeat (10*DIV) step();
        wrF = 1'b1; dataF = 8'hC3;
        step();
        wrF = 1'b0;
        checks += 3;
        if (txdF !== 1'b1)   begin errors++; $display("[TB] FAIL gap txd idle got %b want 1", txdF); end
        if (emptyF !== 1'b0) begin errors++; $display("[TB] FAIL gap empty got %b want 0", emptyF); end
        if (busyF !== 1'b1)  begin errors++; $display("[TB] FAIL gap busy got %b want 1", busyF); end
        for (int j = 0; j < 10*DIV; j++) begin
            step();
            checks++;
            if (txdF !== frameBit(8'hC3, j/DIV)) begin
                errors++; $display("[TB] FAIL gap txd cycle %0d got %b want %b", j, txdF, frameBit(8'hC3, j/DIV));
            end
        end
        step();
        checks++;
        if (busyF !== 1'b0) begin errors++; $display("[TB] FAIL gap busy end got %b want 0", busyF); end
    endtask

    task automatic test_overflow();
        wrF = 1'b1; dataF = 8'd0;
        for (int n = 1; n <= 90*DIV + 2; n++) begin
            step();
            if (n < 10) dataF = 8'(n);
            else if (n == 10) wrF = 1'b0;
            if (n == 9) begin
                checks += 2;
                if (fullF !== 1'b1) begin errors++; $display("[TB] FAIL overflow full after 9 got %b want 1", fullF); end
                if (ovfF !== 1'b0)  begin errors++; $display("[TB] FAIL overflow early flag got %b want 0", ovfF); end
            end
            if (n == 10) begin
                checks += 2;
                if (ovfF !== 1'b1)  begin errors++; $display("[TB] FAIL overflow flag got %b want 1", ovfF); end
                if (fullF !== 1'b1) begin errors++; $display("[TB] FAIL overflow full after 10 got %b want 1", fullF); end
            end
            if (n >= 2 && n <= 90*DIV + 1) begin
                int j;
                j = n - 2;
                checks++;
                if (txdF !== frameBit(8'(j/(10*DIV)), (j % (10*DIV))/DIV)) begin
                    errors++; $display("[TB] FAIL overflow txd cycle %0d got %b want %b", j, txdF,
                                       frameBit(8'(j/(10*DIV)), (j % (10*DIV))/DIV));
                end
            end
        end
        checks += 3;
        if (busyF !== 1'b0)  begin errors++; $display("[TB] FAIL overflow busy end got %b want 0", busyF); end
        if (emptyF !== 1'b1) begin errors++; $display("[TB] FAIL overflow empty end got %b want 1", emptyF); end
        if (ovfF !== 1'b1)   begin errors++; $display("[TB] FAIL overflow sticky got %b want 1", ovfF); end
    endtask

    task automatic test_reset_mid_frame();
        wrF = 1'b1; dataF = 8'h00;
        step();
        dataF = 8'h11;
        step();
        dataF = 8'h22;
        step();
        wrF = 1'b0;
        repeat (16) step();
        checks += 2;
        if (txdF !== 1'b0)   begin errors++; $display("[TB] FAIL midreset txd before got %b want 0", txdF); end
        if (emptyF !== 1'b0) begin errors++; $display("[TB] FAIL midreset empty before got %b want 0", emptyF); end
        #1 nrst = 1'b0;
        #1;
        checks += 4;
        if (txdF !== 1'b1)   begin errors++; $display("[TB] FAIL midreset txd got %b want 1", txdF); end
        if (emptyF !== 1'b1) begin errors++; $display("[TB] FAIL midreset empty got %b want 1", emptyF); end
        if (busyF !== 1'b0)  begin errors++; $display("[TB] FAIL midreset busy got %b want 0", busyF); end
        if (ovfF !== 1'b0)   begin errors++; $display("[TB] FAIL midreset overflow got %b want 0", ovfF); end
        step();
        step();
        nrst = 1'b1;
        for (int j = 0; j < 15*DIV; j++) begin
            step();
            checks++;
            if (txdF !== 1'b1 || busyF !== 1'b0) begin
                errors++; $display("[TB] FAIL midreset residual cycle %0d txd/busy got %b%b want 10", j, txdF, busyF);
            end
        end
    endtask

    task automatic test_default_baud();
        int waited;
        int waveErrs;
        logic [7:0] decoded;
        waveErrs = 0;
        decoded  = 8'h00;
        wrS = 1'b1; dataS = 8'hA5;
        step();
        wrS = 1'b0;
        waited = 0;
        while (txdS !== 1'b0 && waited < 5) begin
            step();
            waited++;
        end
        checks++;
        if (waited != 1) begin
            errors++; $display("[TB] FAIL baud start latency got %0d want 1", waited);
        end else begin
            for (int j = 0; j < 10*SDIV; j++) begin
                if (j != 0) step();
                if (txdS !== frameBit(8'hA5, j/SDIV) || busyS !== 1'b1) waveErrs++;
                if (j/SDIV >= 1 && j/SDIV <= 8 && (j % SDIV) == SDIV/2) decoded[j/SDIV - 1] = txdS;
            end
            step();
            checks += 4;
            if (waveErrs != 0) begin errors++; $display("[TB] FAIL baud waveform bad cycles got %0d want 0", waveErrs); end
            if (decoded !== 8'hA5) begin errors++; $display("[TB] FAIL baud decode got %h want a5", decoded); end
            if (busyS !== 1'b0)    begin errors++; $display("[TB] FAIL baud busy end got %b want 0", busyS); end
            if (txdS !== 1'b1)     begin errors++; $display("[TB] FAIL baud txd end got %b want 1", txdS); end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        step();
        test_back_to_back();
        step();
        test_stop_gap();
        step();
        test_overflow();
        step();
        test_reset_mid_frame();
        test_default_baud();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
